// File: rtl/wb_intercon_n.sv
// wb_intercon_n: registered single-master Wishbone interconnect with address decode, bus error and ACK timeout
module wb_intercon_n #(
  parameter int NUM_SLAVES = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int SEL_BITS   = 4,
  parameter int SEL_LSB    = 28,
  parameter int TIMEOUT    = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             master_STB,
  input  logic                             master_WE,
  input  logic [ADDR_WIDTH-1:0]            master_ADDR,
  input  logic [DATA_WIDTH-1:0]            master_DAT_I,
  output logic [DATA_WIDTH-1:0]            master_DAT_O,
  output logic                             master_ACK,
  output logic                             master_ERR,
  output logic                             busy,
  output logic [NUM_SLAVES-1:0]            slave_STB,
  output logic [NUM_SLAVES-1:0]            slave_WE,
  output logic [ADDR_WIDTH-1:0]            slave_ADDR,
  output logic [DATA_WIDTH-1:0]            slave_DAT_O,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] slave_DAT_I,
  input  logic [NUM_SLAVES-1:0]            slave_ACK
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  state_t                r_state, w_state;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [NUM_SLAVES-1:0] r_stb, w_stb, r_we, w_we;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr;
  logic [DATA_WIDTH-1:0] r_wdat, w_wdat, r_rdat, w_rdat, w_sdat;
  logic                  r_ack, w_ack, r_err, w_err;
  logic [SEL_BITS-1:0]   w_idx;
  logic                  w_hit, w_sack, w_tmo;
  assign w_idx  = master_ADDR[SEL_LSB +: SEL_BITS];
  assign w_hit  = {1'b0, w_idx} < (SEL_BITS + 1)'(NUM_SLAVES);
  assign w_sack = |(slave_ACK & r_stb);
  assign w_tmo  = TIMEOUT != 0 && r_cnt == CW'(TIMEOUT - 1);
  // read data of the currently strobed slave (the strobe is one-hot)
  always_comb begin
    w_sdat = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      w_sdat = w_sdat | (r_stb[i] ? slave_DAT_I[i*DATA_WIDTH +: DATA_WIDTH] : '0);
  end
  // next-state and next-output logic; ACK beats timeout, timeout beats abort
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_stb   = r_stb;
    w_we    = r_we;
    w_addr  = r_addr;
    w_wdat  = r_wdat;
    w_rdat  = r_rdat;
    w_ack   = 1'b0;
    w_err   = 1'b0;
    case (r_state)
      IDLE: if (master_STB) begin
        w_addr  = master_ADDR;
        w_wdat  = master_DAT_I;
        w_cnt   = '0;
        w_stb   = w_hit ? NUM_SLAVES'(1) << w_idx : '0;
        w_we    = master_WE ? w_stb : '0;
        w_err   = !w_hit;
        w_state = w_hit ? BUSY : RESP;
      end
      BUSY: if (w_sack) begin
        w_stb   = '0;
        w_we    = '0;
        w_ack   = 1'b1;
        w_rdat  = |r_we ? r_rdat : w_sdat;
        w_state = RESP;
      end else if (w_tmo) begin
        w_stb   = '0;
        w_we    = '0;
        w_err   = 1'b1;
        w_state = RESP;
      end else if (!master_STB) begin
        w_stb   = '0;
        w_we    = '0;
        w_state = IDLE;
      end else begin
        w_cnt = r_cnt == CW'(TIMEOUT) ? r_cnt : r_cnt + 1'b1;
      end
      default: w_state = IDLE;
    endcase
  end
  // state and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_stb   <= '0;
      r_we    <= '0;
      r_addr  <= '0;
      r_wdat  <= '0;
      r_rdat  <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_stb   <= w_stb;
      r_we    <= w_we;
      r_addr  <= w_addr;
      r_wdat  <= w_wdat;
      r_rdat  <= w_rdat;
      r_ack   <= w_ack;
      r_err   <= w_err;
    end
  end
  assign master_DAT_O = r_rdat;
  assign master_ACK   = r_ack;
  assign master_ERR   = r_err;
  assign busy         = r_state == BUSY;
  assign slave_STB    = r_stb;
  assign slave_WE     = r_we;
  assign slave_ADDR   = r_addr;
  assign slave_DAT_O  = r_wdat;
endmodule

// File: doc/wb_intercon_n.md
# wb_intercon_n

Parametrised, registered single-master Wishbone interconnect. It routes one CPU bus master to NUM_SLAVES memory-mapped devices (RAM, seven-seg, VGA, keyboard, and later additions) by decoding an address field. It adds a bus-error response for unmapped addresses and a per-transaction ACK timeout. It sits between the CPU and the device slaves in the top level.

## Interface

Parameters:
- NUM_SLAVES, 4: number of attached slaves, 1..2^SEL_BITS.
- DATA_WIDTH, 32: data bus width.
- ADDR_WIDTH, 32: address bus width.
- SEL_BITS, 4: width of the slave-select address field.
- SEL_LSB, 28: lowest address bit of the select field; index = master_ADDR[SEL_LSB +: SEL_BITS].
- TIMEOUT, 255: cycles to wait for slave ACK; 0 disables the timeout.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- master_STB  in  1  master strobe/cycle request.
- master_WE  in  1  1 = write, 0 = read.
- master_ADDR  in  ADDR_WIDTH  byte address.
- master_DAT_I  in  DATA_WIDTH  write data from master.
- master_DAT_O  out  DATA_WIDTH  read data to master.
- master_ACK  out  1  one-cycle completion pulse.
- master_ERR  out  1  one-cycle error pulse (unmapped or timeout).
- busy  out  1  high while a slave transaction is outstanding.
- slave_STB  out  NUM_SLAVES  one-hot strobe; bit i selects slave i.
- slave_WE  out  NUM_SLAVES  write enable, gated per slave like slave_STB.
- slave_ADDR  out  ADDR_WIDTH  latched address, shared by all slaves.
- slave_DAT_O  out  DATA_WIDTH  latched write data, shared by all slaves.
- slave_DAT_I  in  NUM_SLAVES*DATA_WIDTH  concatenated read data; slave i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- slave_ACK  in  NUM_SLAVES  per-slave acknowledge.

## Operation

FSM states are IDLE, BUSY and RESP. Every output is registered.

- **IDLE:**
  - When master_STB=1, latch ADDR, WE, DAT_I and idx.
  - If idx < NUM_SLAVES: set slave_STB[idx]=1 and slave_WE[idx]=master_WE, clear the timeout counter, then go to BUSY.
  - Otherwise: set master_ERR=1, drive no slave strobe, then go to RESP.
- **BUSY:**
  - Hold slave_STB, slave_WE, slave_ADDR and slave_DAT_O stable.
  - The counter increments once per cycle.
  - Only slave_ACK[idx] is observed. ACKs from other slaves are ignored.
- **ACK handling in BUSY:**
  - On slave_ACK[idx]=1, clear slave_STB and slave_WE.
  - Pulse master_ACK.
  - On a read, load master_DAT_O from the slave's slice of slave_DAT_I.
  - Go to RESP.
- **Timeout in BUSY:**
  - If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with no ACK, clear the strobes, pulse master_ERR and go to RESP.
  - If ACK and timeout occur in the same cycle, ACK wins.
- **Abort in BUSY:**
  - If master_STB=0, clear the strobes and go to IDLE.
  - No ACK and no ERR are produced.
- **RESP:**
  - master_ACK and master_ERR fall.
  - Go to IDLE unconditionally. A still-high master_STB is then accepted as a new request from IDLE.
- master_DAT_O holds its last read value. Writes and errors leave it unchanged.
- busy = (state==BUSY).
- Counter width is $clog2(TIMEOUT+1). It saturates and does not wrap.

## Timing

- **Reset values:**
  - master_ACK=0, master_ERR=0, master_DAT_O=0, busy=0.
  - slave_STB=0, slave_WE=0, slave_ADDR=0, slave_DAT_O=0.
  - State = IDLE, counter = 0.
- **Reset mid-transaction:** strobes drop at the reset edge. No ACK or ERR is issued.
- **Mapped access with a zero-wait slave:**
  - master_STB sampled at edge 0.
  - slave_STB high during cycle 1.
  - Slave ACKs combinationally in cycle 1.
  - master_ACK high during cycle 2.
  - Request-to-ACK latency is 2 cycles, plus k for k slave wait states.
- **Unmapped access:** master_ERR is high in cycle 1.
- **Timeout:** master_ERR rises TIMEOUT+1 cycles after STB is sampled.
- master_ACK and master_ERR are each exactly one cycle wide and never high together.
- slave_STB is at most one-hot at all times.
- **Throughput:** at most one transaction per 3 cycles (IDLE→BUSY→RESP).
- slave_ACK arriving in RESP or IDLE is ignored.

## Test plan

- **Read from slave 2:** NUM_SLAVES=4, SEL_LSB=28. Read 0x2000_0010 with slave 2 ACKing immediately and data 0xDEAD_BEEF.
  - slave_STB=4'b0100 in cycle 1.
  - master_ACK in cycle 2.
  - master_DAT_O=0xDEAD_BEEF.
- **Write to slave 1:** write 0x1000_0004 with data 0x55, and slave 1 holds ACK off for 3 cycles.
  - slave_WE[1]=1 and slave_DAT_O=0x55, stable for 4 cycles.
  - master_ACK in cycle 5.
  - master_DAT_O unchanged.
- **Unmapped address:** access 0x7000_0000.
  - master_ERR in cycle 1.
  - slave_STB stays 0.
  - No ACK.
- **Timeout:** TIMEOUT=8, slave never ACKs.
  - slave_STB drops and master_ERR pulses in cycle 9.
  - A spurious ACK from slave 3 during the wait has no effect.
  - An ACK arriving later is ignored.
- **Abort and reset:**
  - Drop master_STB in cycle 2 of a pending access: strobes clear, no ACK, busy=0.
  - Assert reset during BUSY: all outputs return to 0 at the next edge.
- **Back-to-back:** hold master_STB high across two reads. The second slave_STB appears 3 cycles after the first.
